// File: rtl/fp_serial_tx.sv
// fp_serial_tx: buffers compressed {S,E,F} samples in a small FIFO and sends
// each one as an 11-bit frame: start, 8 data bits MSB-first, even parity, stop.
module fp_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_s,
  input  logic [2:0]               in_e,
  input  logic [3:0]               in_f,
  output logic                     in_ready,
  output logic                     tx_line,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   baud;
  logic [BW-1:0]   baud_next;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_next;
  logic [7:0]      shreg;
  logic            parity;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            baud_done;
  logic            line_next;
  logic            queued;

  // in_ready looks only at the registered count, so a pop on the same edge
  // never lets a full FIFO accept a new sample.
  assign in_ready  = (fifo_count < FULL);
  assign push      = in_valid && in_ready;
  assign baud_done = (baud == BAUD_LAST);
  assign queued    = (fifo_count != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, baud/bit counters and pop decision; baud restarts on every state change.
  always_comb begin
    state_next   = state;
    baud_next    = baud + 1'b1;
    bit_idx_next = bit_idx;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (queued) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          state_next   = DATA;
          baud_next    = '0;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_done) begin
          state_next = STOP;
          baud_next  = '0;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (queued) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the state being entered.
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = shreg[3'd7 - bit_idx_next];
      PARITY:  line_next = parity;
      default: line_next = 1'b1;
    endcase
  end

  // Transmitter datapath: counters, shifter load on pop, registered line and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud    <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      parity  <= 1'b0;
      tx_line <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      tx_line <= line_next;
      tx_busy <= (state_next != IDLE);
      if (pop) begin
        shreg  <= mem[rd_ptr];
        parity <= ^mem[rd_ptr];
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {in_s, in_e, in_f};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
